// File: rtl/cpu_datapath_if.sv
// Purpose: control/status bundle between the CPU controller (plus memory read port) and the datapath.
// Latency: pure wiring, no storage.
// Backpressure: none; the controller sequences every operation and the datapath never stalls.
interface cpu_datapath_if #(
   parameter int WIDTH = 16
);
   // memory read port (combinational read at memAddress)
   logic [WIDTH-1:0] memData;
   logic [WIDTH-1:0] memAddress;

   // control from the controller
   logic [1:0]       memAddr;
   logic             enPC;
   logic             saveOpcode;
   logic             saveMem;
   logic [3:0]       aluFunc;
   logic [2:0]       aluA;
   logic [2:0]       aluB;
   logic             enA;
   logic             enB;
   logic             enC;

   // status back to the controller / debug
   logic [15:0]      opcode;
   logic [WIDTH-1:0] regA;
   logic [WIDTH-1:0] regB;
   logic [WIDTH-1:0] regC;
   logic [2:0]       flags;

   modport master (
      output memData, memAddr, enPC, saveOpcode, saveMem,
             aluFunc, aluA, aluB, enA, enB, enC,
      input  opcode, memAddress, regA, regB, regC, flags
   );

   modport slave (
      input  memData, memAddr, enPC, saveOpcode, saveMem,
             aluFunc, aluA, aluB, enA, enB, enC,
      output opcode, memAddress, regA, regB, regC, flags
   );
endinterface

// File: rtl/cpu_datapath.sv
// Purpose: multi-cycle CPU register file (PC, IR, MEM, A/B/C, flags), operand muxes and ALU.
// Latency: memAddress and ALU result combinational; every register write lands on the next rising edge.
// Backpressure: none; every control input is consumed in the cycle it is asserted.
module cpu_datapath #(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst,
   cpu_datapath_if.slave  bus
);

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_AND    = 4'd2,
      ALU_OR     = 4'd3,
      ALU_XOR    = 4'd4,
      ALU_PASS_A = 4'd5,
      ALU_NOT_A  = 4'd6,
      ALU_NEG_A  = 4'd7,
      ALU_PASS_B = 4'd12,
      ALU_SHL    = 4'd13,
      ALU_SHR    = 4'd14,
      ALU_SAR    = 4'd15
   } alu_func_e;

   // architectural state
   logic [WIDTH-1:0] pc_q,  pc_d;
   logic [15:0]      ir_q,  ir_d;
   logic [WIDTH-1:0] mem_q, mem_d;
   logic [WIDTH-1:0] a_q,   a_d;
   logic [WIDTH-1:0] b_q,   b_d;
   logic [WIDTH-1:0] c_q,   c_d;
   logic [2:0]       flags_q, flags_d;   // {N, C, Z}

   // datapath wires
   logic [WIDTH-1:0] imm;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [3:0]       shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cy;
   logic signed [WIDTH:0] sar_ext;
   logic             any_reg_wr;

   // Immediate is the low opcode byte, sign-extended to the datapath width
   assign imm   = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
   assign shamt = op_b[3:0];

   // Memory address source select; reads pre-edge register values
   always_comb begin
      bus.memAddress = '0;
      case (bus.memAddr)
         2'd0:    bus.memAddress = pc_q;
         2'd1:    bus.memAddress = a_q;
         2'd2:    bus.memAddress = c_q;
         default: bus.memAddress = '0;
      endcase
   end

   // ALU operand A source select
   always_comb begin
      op_a = '0;
      case (bus.aluA)
         3'd0:    op_a = a_q;
         3'd1:    op_a = b_q;
         3'd2:    op_a = c_q;
         3'd4:    op_a = pc_q;
         3'd5:    op_a = mem_q;
         default: op_a = '0;
      endcase
   end

   // ALU operand B source select
   always_comb begin
      op_b = '0;
      case (bus.aluB)
         3'd0:    op_b = a_q;
         3'd1:    op_b = b_q;
         3'd2:    op_b = c_q;
         3'd4:    op_b = {{(WIDTH-1){1'b0}}, 1'b1};
         3'd5:    op_b = imm;
         default: op_b = '0;
      endcase
   end

   // ALU: result plus carry/borrow/last-shifted-out bit; reserved codes yield zero
   always_comb begin
      alu_res = '0;
      alu_cy  = 1'b0;
      sar_ext = $signed({op_a, 1'b0}) >>> shamt;
      case (bus.aluFunc)
         ALU_ADD:    {alu_cy, alu_res} = {1'b0, op_a} + {1'b0, op_b};
         ALU_SUB: begin
            alu_res = op_a - op_b;
            alu_cy  = (op_a < op_b);
         end
         ALU_AND:    alu_res = op_a & op_b;
         ALU_OR:     alu_res = op_a | op_b;
         ALU_XOR:    alu_res = op_a ^ op_b;
         ALU_PASS_A: alu_res = op_a;
         ALU_NOT_A:  alu_res = ~op_a;
         ALU_NEG_A: begin
            alu_res = '0 - op_a;
            alu_cy  = |op_a;
         end
         ALU_PASS_B: alu_res = op_b;
         // the extra bit above/below the operand catches the last bit shifted out,
         // and stays 0 for a zero shift amount
         ALU_SHL:    {alu_cy, alu_res} = {1'b0, op_a} << shamt;
         ALU_SHR:    {alu_res, alu_cy} = {op_a, 1'b0} >> shamt;
         ALU_SAR:    {alu_res, alu_cy} = sar_ext;
         default: begin
            alu_res = '0;
            alu_cy  = 1'b0;
         end
      endcase
   end

   assign any_reg_wr = bus.enA | bus.enB | bus.enC;

   // Next-state for every register; flags follow only general-register writes
   always_comb begin
      pc_d    = pc_q;
      ir_d    = ir_q;
      mem_d   = mem_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      flags_d = flags_q;
      if (bus.enPC)       pc_d  = alu_res;
      if (bus.saveOpcode) ir_d  = bus.memData[15:0];
      if (bus.saveMem)    mem_d = bus.memData;
      if (bus.enA)        a_d   = alu_res;
      if (bus.enB)        b_d   = alu_res;
      if (bus.enC)        c_d   = alu_res;
      if (any_reg_wr)     flags_d = {alu_res[WIDTH-1], alu_cy, (alu_res == '0)};
   end

   // State registers; reset clears everything and drops any write in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= '0;
         ir_q    <= '0;
         mem_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         flags_q <= '0;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         mem_q   <= mem_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         flags_q <= flags_d;
      end
   end

   assign bus.opcode = ir_q;
   assign bus.regA   = a_q;
   assign bus.regB   = b_q;
   assign bus.regC   = c_q;
   assign bus.flags  = flags_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Purpose: directed self-checking bench for cpu_datapath with a small behavioural memory.
// Latency: inputs driven 1ns after the rising edge, register effects checked 1ns after the next edge.
// Backpressure: none; the bench acts as the controller and sequences every cycle.
module tb_cpu_datapath;

   logic        clk;
   logic        rst;
   logic        ovr_en;
   logic [15:0] ovr_val;
   int          checks;
   int          errors;

   cpu_datapath_if #(.WIDTH(16)) bus ();

   cpu_datapath #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory contents: a few fixed words, a hashed pattern elsewhere
   function automatic logic [15:0] mem_model(input logic [15:0] addr);
      case (addr)
         16'h0000: mem_model = 16'h0A41;
         16'hFFFF: mem_model = 16'hBEEF;
         16'h0010: mem_model = 16'h1357;
         default:  mem_model = addr ^ 16'h5A5A;
      endcase
   endfunction

   // override lets the bench inject an arbitrary word regardless of address
   assign bus.memData = ovr_en ? ovr_val : mem_model(bus.memAddress);

   task automatic idle();
      bus.memAddr    = 2'd0;
      bus.enPC       = 1'b0;
      bus.saveOpcode = 1'b0;
      bus.saveMem    = 1'b0;
      bus.aluFunc    = 4'd0;
      bus.aluA       = 3'd0;
      bus.aluB       = 3'd0;
      bus.enA        = 1'b0;
      bus.enB        = 1'b0;
      bus.enC        = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fetch();
      idle();
      bus.memAddr    = 2'd0;
      bus.saveOpcode = 1'b1;
      bus.enPC       = 1'b1;
      bus.aluA       = 3'd4;
      bus.aluB       = 3'd4;
      bus.aluFunc    = 4'd0;
   endtask

   // sel: 0=A 1=B 2=C ; value goes MEM -> PASS_A -> register
   task automatic load_reg(input int sel, input logic [15:0] val);
      idle();
      ovr_en      = 1'b1;
      ovr_val     = val;
      bus.memAddr = 2'd3;
      bus.saveMem = 1'b1;
      step();
      idle();
      ovr_en      = 1'b0;
      bus.aluA    = 3'd5;
      bus.aluFunc = 4'd5;
      bus.enA     = (sel == 0);
      bus.enB     = (sel == 1);
      bus.enC     = (sel == 2);
      step();
      idle();
   endtask

   task automatic test_reset();
      #2;
      checks++; if (bus.regA !== 16'h0) begin errors++; $display("FAIL rst_hold_a got %h exp 0000", bus.regA); end
      checks++; if (bus.opcode !== 16'h0 || bus.memAddress !== 16'h0 || bus.flags !== 3'b000) begin
         errors++; $display("FAIL rst_hold_outs got op=%h addr=%h fl=%b exp 0", bus.opcode, bus.memAddress, bus.flags); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      load_reg(0, 16'h1234);
      checks++; if (bus.regA !== 16'h1234) begin errors++; $display("FAIL rst_preload_a got %h exp 1234", bus.regA); end
      // assert reset between edges with a write pending
      bus.aluA = 3'd3; bus.aluB = 3'd4; bus.aluFunc = 4'd12; bus.enA = 1'b1; bus.enB = 1'b1;
      #3 rst = 1'b1;
      #1;
      checks++; if (bus.regA !== 16'h0 || bus.regB !== 16'h0 || bus.regC !== 16'h0) begin
         errors++; $display("FAIL rst_async_regs got %h %h %h exp 0", bus.regA, bus.regB, bus.regC); end
      checks++; if (bus.opcode !== 16'h0 || bus.memAddress !== 16'h0 || bus.flags !== 3'b000) begin
         errors++; $display("FAIL rst_async_outs got op=%h addr=%h fl=%b exp 0", bus.opcode, bus.memAddress, bus.flags); end
      step();
      checks++; if (bus.regA !== 16'h0) begin errors++; $display("FAIL rst_drop_write got %h exp 0000", bus.regA); end
      rst = 1'b0;
      set_fetch();
      #1;
      checks++; if (bus.memAddress !== 16'h0000) begin errors++; $display("FAIL fetch0_addr got %h exp 0000", bus.memAddress); end
      step();
      checks++; if (bus.opcode !== 16'h0A41) begin errors++; $display("FAIL fetch0_ir got %h exp 0a41", bus.opcode); end
      checks++; if (bus.memAddress !== 16'h0001) begin errors++; $display("FAIL fetch0_pc got %h exp 0001", bus.memAddress); end
      idle();
   endtask

   task automatic test_fetch_wrap();
      load_reg(0, 16'hFFFF);               // flags become {N=1,C=0,Z=0}
      bus.aluA = 3'd0; bus.aluFunc = 4'd5; bus.enPC = 1'b1;
      step();
      set_fetch();
      #1;
      checks++; if (bus.memAddress !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr got %h exp ffff", bus.memAddress); end
      step();
      checks++; if (bus.opcode !== 16'hBEEF) begin errors++; $display("FAIL wrap_ir got %h exp beef", bus.opcode); end
      checks++; if (bus.memAddress !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h exp 0000", bus.memAddress); end
      checks++; if (bus.flags !== 3'b100) begin errors++; $display("FAIL wrap_flags got %b exp 100", bus.flags); end
      idle();
   endtask

   task automatic test_add();
      load_reg(0, 16'h7FFF);
      load_reg(1, 16'h0001);
      bus.aluFunc = 4'd0; bus.aluA = 3'd0; bus.aluB = 3'd1; bus.enC = 1'b1;
      step();
      checks++; if (bus.regC !== 16'h8000) begin errors++; $display("FAIL add_c got %h exp 8000", bus.regC); end
      checks++; if (bus.flags !== 3'b100) begin errors++; $display("FAIL add_flags got %b exp 100", bus.flags); end
      idle();
   endtask

   task automatic test_sub();
      load_reg(0, 16'h0003);
      load_reg(1, 16'h0003);
      bus.aluFunc = 4'd1; bus.aluA = 3'd0; bus.aluB = 3'd1; bus.enA = 1'b1;
      step();
      checks++; if (bus.regA !== 16'h0000) begin errors++; $display("FAIL sub_eq_a got %h exp 0000", bus.regA); end
      checks++; if (bus.flags !== 3'b001) begin errors++; $display("FAIL sub_eq_flags got %b exp 001", bus.flags); end
      load_reg(0, 16'h0002);
      bus.aluFunc = 4'd1; bus.aluA = 3'd0; bus.aluB = 3'd1; bus.enA = 1'b1;
      step();
      checks++; if (bus.regA !== 16'hFFFF) begin errors++; $display("FAIL sub_neg_a got %h exp ffff", bus.regA); end
      checks++; if (bus.flags !== 3'b110) begin errors++; $display("FAIL sub_neg_flags got %b exp 110", bus.flags); end
      idle();
   endtask

   task automatic test_imm_shift();
      ovr_en = 1'b1; ovr_val = 16'h40FE;
      bus.memAddr = 2'd3; bus.saveOpcode = 1'b1;
      step();
      idle(); ovr_en = 1'b0;
      checks++; if (bus.opcode !== 16'h40FE) begin errors++; $display("FAIL imm_ir got %h exp 40fe", bus.opcode); end
      bus.aluA = 3'd3; bus.aluB = 3'd5; bus.aluFunc = 4'd12; bus.enB = 1'b1;
      step();
      checks++; if (bus.regB !== 16'hFFFE) begin errors++; $display("FAIL imm_b got %h exp fffe", bus.regB); end
      idle();
      bus.aluA = 3'd1; bus.aluB = 3'd4; bus.aluFunc = 4'd15; bus.enB = 1'b1;
      step();
      checks++; if (bus.regB !== 16'hFFFF) begin errors++; $display("FAIL sar_b got %h exp ffff", bus.regB); end
      checks++; if (bus.flags !== 3'b100) begin errors++; $display("FAIL sar_flags got %b exp 100", bus.flags); end
      idle();
      bus.aluA = 3'd1; bus.aluB = 3'd4; bus.aluFunc = 4'd14; bus.enC = 1'b1;
      step();
      checks++; if (bus.regC !== 16'h7FFF) begin errors++; $display("FAIL shr_c got %h exp 7fff", bus.regC); end
      checks++; if (bus.flags !== 3'b010) begin errors++; $display("FAIL shr_flags got %b exp 010", bus.flags); end
      idle();
   endtask

   task automatic test_indirect();
      load_reg(0, 16'h0010);
      bus.memAddr = 2'd1; bus.saveMem = 1'b1;
      bus.aluA = 3'd0; bus.aluB = 3'd4; bus.aluFunc = 4'd0; bus.enA = 1'b1;
      #1;
      checks++; if (bus.memAddress !== 16'h0010) begin errors++; $display("FAIL ind_addr got %h exp 0010", bus.memAddress); end
      step();
      checks++; if (bus.regA !== 16'h0011) begin errors++; $display("FAIL ind_a got %h exp 0011", bus.regA); end
      idle();
      bus.memAddr = 2'd1; bus.aluA = 3'd5; bus.aluFunc = 4'd5; bus.enB = 1'b1;
      step();
      checks++; if (bus.regB !== 16'h1357) begin errors++; $display("FAIL ind_mem_b got %h exp 1357", bus.regB); end
      checks++; if (bus.memAddress !== 16'h0011) begin errors++; $display("FAIL ind_addr_new got %h exp 0011", bus.memAddress); end
      idle();
   endtask

   task automatic test_alu_misc();
      load_reg(0, 16'h0005);
      bus.aluA = 3'd0; bus.aluFunc = 4'd7; bus.enC = 1'b1;
      step();
      checks++; if (bus.regC !== 16'hFFFB || bus.flags !== 3'b110) begin
         errors++; $display("FAIL neg got c=%h fl=%b exp fffb 110", bus.regC, bus.flags); end
      idle();
      bus.aluA = 3'd0; bus.aluB = 3'd0; bus.aluFunc = 4'd9; bus.enC = 1'b1;
      step();
      checks++; if (bus.regC !== 16'h0000 || bus.flags !== 3'b001) begin
         errors++; $display("FAIL reserved got c=%h fl=%b exp 0000 001", bus.regC, bus.flags); end
      idle();
      load_reg(0, 16'h8001);
      bus.aluA = 3'd0; bus.aluB = 3'd4; bus.aluFunc = 4'd13; bus.enC = 1'b1;
      step();
      checks++; if (bus.regC !== 16'h0002 || bus.flags !== 3'b010) begin
         errors++; $display("FAIL shl got c=%h fl=%b exp 0002 010", bus.regC, bus.flags); end
      idle();
   endtask

   task automatic test_back_to_back();
      // both A and B written with the same value, then XOR them in the next cycle
      bus.aluA = 3'd3; bus.aluB = 3'd4; bus.aluFunc = 4'd12; bus.enA = 1'b1; bus.enB = 1'b1;
      step();
      checks++; if (bus.regA !== 16'h0001 || bus.regB !== 16'h0001) begin
         errors++; $display("FAIL multi_wr got a=%h b=%h exp 0001 0001", bus.regA, bus.regB); end
      idle();
      bus.aluA = 3'd0; bus.aluB = 3'd1; bus.aluFunc = 4'd4; bus.enC = 1'b1;
      step();
      checks++; if (bus.regC !== 16'h0000 || bus.flags !== 3'b001) begin
         errors++; $display("FAIL xor got c=%h fl=%b exp 0000 001", bus.regC, bus.flags); end
      idle();
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      ovr_en  = 1'b0;
      ovr_val = 16'h0;
      idle();
      test_reset();
      test_fetch_wrap();
      test_add();
      test_sub();
      test_imm_shift();
      test_indirect();
      test_alu_misc();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
